// File: rtl/ram_arbiter_if.sv
// Bundle of the two client command ports and the single-port-pair RAM interface
// seen by ram_arbiter; slave is the arbiter side, master the client/RAM side.
interface ram_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  // Handshake: cN_req is a valid that holds cN_we/addr/wdata stable until cN_gnt
  // is seen high in the same cycle; req low before gnt withdraws the command.
  logic              c0_req;
  logic              c0_we;
  logic [ADDR_W-1:0] c0_addr;
  logic [DATA_W-1:0] c0_wdata;
  logic              c0_gnt;
  logic              c0_rvalid;
  logic [DATA_W-1:0] c0_rdata;

  logic              c1_req;
  logic              c1_we;
  logic [ADDR_W-1:0] c1_addr;
  logic [DATA_W-1:0] c1_wdata;
  logic              c1_gnt;
  logic              c1_rvalid;
  logic [DATA_W-1:0] c1_rdata;

  logic              write_en;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] data_in;
  logic              read_en;
  logic [ADDR_W-1:0] read_address;
  logic [DATA_W-1:0] data_out;

  modport slave (
    input  c0_req, c0_we, c0_addr, c0_wdata,
    input  c1_req, c1_we, c1_addr, c1_wdata,
    input  data_out,
    output c0_gnt, c0_rvalid, c0_rdata,
    output c1_gnt, c1_rvalid, c1_rdata,
    output write_en, write_address, data_in,
    output read_en, read_address
  );

  modport master (
    output c0_req, c0_we, c0_addr, c0_wdata,
    output c1_req, c1_we, c1_addr, c1_wdata,
    output data_out,
    input  c0_gnt, c0_rvalid, c0_rdata,
    input  c1_gnt, c1_rvalid, c1_rdata,
    input  write_en, write_address, data_in,
    input  read_en, read_address
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-client arbiter onto a RAM with separate write and read ports; each port is
// round-robin arbitrated on its own, and a read colliding with the winning write is held off.
module ram_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);

  logic              wr_pri_q, wr_pri_d;
  logic              rd_pri_q, rd_pri_d;
  logic              w0, w1, r0, r1;
  logic              wr_any, rd_any, wr_sel, rd_sel;
  logic              hazard, wr_go, rd_go;
  logic [ADDR_W-1:0] wr_addr_sel, rd_addr_sel;
  logic [DATA_W-1:0] wr_data_sel;

  logic              write_en_q;
  logic [ADDR_W-1:0] write_address_q;
  logic [DATA_W-1:0] data_in_q;
  logic              read_en_q;
  logic [ADDR_W-1:0] read_address_q;
  logic              rd_owner_q;
  logic              c0_rvalid_q, c1_rvalid_q;

  always_comb begin
    w0 = bus.c0_req & bus.c0_we;
    w1 = bus.c1_req & bus.c1_we;
    r0 = bus.c0_req & ~bus.c0_we;
    r1 = bus.c1_req & ~bus.c1_we;

    wr_any = w0 | w1;
    rd_any = r0 | r1;
    wr_sel = (w0 & w1) ? wr_pri_q : w1;
    rd_sel = (r0 & r1) ? rd_pri_q : r1;

    wr_addr_sel = wr_sel ? bus.c1_addr  : bus.c0_addr;
    wr_data_sel = wr_sel ? bus.c1_wdata : bus.c0_wdata;
    rd_addr_sel = rd_sel ? bus.c1_addr  : bus.c0_addr;

    // Same-address read waits so it never races the write it would collide with.
    hazard = wr_any & rd_any & (wr_addr_sel == rd_addr_sel);
    wr_go  = wr_any & ~rst;
    rd_go  = rd_any & ~hazard & ~rst;

    wr_pri_d = wr_go ? ~wr_sel : wr_pri_q;
    rd_pri_d = rd_go ? ~rd_sel : rd_pri_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_pri_q        <= 1'b0;
      rd_pri_q        <= 1'b0;
      write_en_q      <= 1'b0;
      write_address_q <= '0;
      data_in_q       <= '0;
      read_en_q       <= 1'b0;
      read_address_q  <= '0;
      rd_owner_q      <= 1'b0;
      c0_rvalid_q     <= 1'b0;
      c1_rvalid_q     <= 1'b0;
    end else begin
      wr_pri_q   <= wr_pri_d;
      rd_pri_q   <= rd_pri_d;
      write_en_q <= wr_go;
      if (wr_go) begin
        write_address_q <= wr_addr_sel;
        data_in_q       <= wr_data_sel;
      end
      read_en_q <= rd_go;
      if (rd_go) begin
        read_address_q <= rd_addr_sel;
        rd_owner_q     <= rd_sel;
      end
      // The RAM returns data the cycle after read_en, so the owner rides one stage behind it.
      c0_rvalid_q <= read_en_q & ~rd_owner_q;
      c1_rvalid_q <= read_en_q &  rd_owner_q;
    end
  end

  assign bus.c0_gnt        = (wr_go & ~wr_sel) | (rd_go & ~rd_sel);
  assign bus.c1_gnt        = (wr_go &  wr_sel) | (rd_go &  rd_sel);
  assign bus.c0_rvalid     = c0_rvalid_q;
  assign bus.c1_rvalid     = c1_rvalid_q;
  assign bus.c0_rdata      = bus.data_out;
  assign bus.c1_rdata      = bus.data_out;
  assign bus.write_en      = write_en_q;
  assign bus.write_address = write_address_q;
  assign bus.data_in       = data_in_q;
  assign bus.read_en       = read_en_q;
  assign bus.read_address  = read_address_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a RAM model, a cycle-level reference model checked every
// cycle, and directed scenarios with literal expectations.
module tb_ram_arbiter;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int QW     = 32 + 1 + DATA_W;
  localparam int DEPTH  = 1 << ADDR_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM behaviour: write on the edge, read data registered for the next cycle
  logic [DATA_W-1:0] ram_mem [0:DEPTH-1];
  initial for (int i = 0; i < DEPTH; i++) ram_mem[i] = '0;
  always @(posedge clk) begin
    if (bus.write_en) ram_mem[bus.write_address] <= bus.data_in;
    if (bus.read_en)  bus.data_out <= ram_mem[bus.read_address];
  end

  // reference model: priorities, last-cycle grants, and a scoreboard of pending returns
  int                m_wpri, m_rpri, mcyc;
  logic              m_we, m_re;
  logic [ADDR_W-1:0] m_waddr, m_raddr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  logic [QW-1:0]     exp_q[$];

  initial begin
    int                w0, w1, r0, r1, ws, rs;
    bit                wv, rv, wgo, rgo, eg0, eg1, ev0, ev1;
    logic [ADDR_W-1:0] wa, ra;
    logic [DATA_W-1:0] wd, edata;
    m_wpri = 0; m_rpri = 0; mcyc = 0;
    m_we = 1'b0; m_re = 1'b0; m_waddr = '0; m_raddr = '0; m_wdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    forever begin
      @(negedge clk);
      w0 = int'(bus.c0_req && bus.c0_we);
      w1 = int'(bus.c1_req && bus.c1_we);
      r0 = int'(bus.c0_req && !bus.c0_we);
      r1 = int'(bus.c1_req && !bus.c1_we);
      wv = (w0 + w1) > 0;
      rv = (r0 + r1) > 0;
      ws = (w0 == 1 && w1 == 1) ? m_wpri : w1;
      rs = (r0 == 1 && r1 == 1) ? m_rpri : r1;
      wa = (ws == 1) ? bus.c1_addr  : bus.c0_addr;
      wd = (ws == 1) ? bus.c1_wdata : bus.c0_wdata;
      ra = (rs == 1) ? bus.c1_addr  : bus.c0_addr;
      wgo = !rst && wv;
      rgo = !rst && rv && !(wv && wa == ra);
      eg0 = (wgo && ws == 0) || (rgo && rs == 0);
      eg1 = (wgo && ws == 1) || (rgo && rs == 1);

      ev0 = 1'b0; ev1 = 1'b0; edata = '0;
      if (exp_q.size() > 0 && int'(exp_q[0][QW-1 -: 32]) == mcyc) begin
        ev0   = (exp_q[0][DATA_W] == 1'b0);
        ev1   = (exp_q[0][DATA_W] == 1'b1);
        edata = exp_q[0][DATA_W-1:0];
      end

      chk("m_c0_gnt", bus.c0_gnt, eg0);
      chk("m_c1_gnt", bus.c1_gnt, eg1);
      chk("m_write_en", bus.write_en, m_we);
      if (m_we) begin
        chk("m_write_address", bus.write_address, m_waddr);
        chk("m_data_in", bus.data_in, m_wdata);
      end
      chk("m_read_en", bus.read_en, m_re);
      if (m_re) chk("m_read_address", bus.read_address, m_raddr);
      chk("m_c0_rvalid", bus.c0_rvalid, ev0);
      chk("m_c1_rvalid", bus.c1_rvalid, ev1);
      if (ev0) chk("m_c0_rdata", bus.c0_rdata, edata);
      if (ev1) chk("m_c1_rdata", bus.c1_rdata, edata);

      // advance the model across the coming edge
      if (rst) begin
        m_wpri = 0; m_rpri = 0;
        m_we = 1'b0; m_re = 1'b0; m_waddr = '0; m_raddr = '0; m_wdata = '0;
        exp_q.delete();
      end else begin
        if (exp_q.size() > 0 && int'(exp_q[0][QW-1 -: 32]) == mcyc) void'(exp_q.pop_front());
        m_we = wgo;
        m_re = rgo;
        if (rgo) begin
          m_raddr = ra;
          exp_q.push_back({32'(mcyc + 2), 1'(rs), ref_mem[ra]});
          m_rpri = 1 - rs;
        end
        if (wgo) begin
          m_waddr = wa;
          m_wdata = wd;
          ref_mem[wa] = wd;
          m_wpri = 1 - ws;
        end
      end
      mcyc++;
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.c0_req = 1'b0; bus.c0_we = 1'b0; bus.c0_addr = '0; bus.c0_wdata = '0;
    bus.c1_req = 1'b0; bus.c1_we = 1'b0; bus.c1_addr = '0; bus.c1_wdata = '0;
  endtask

  task automatic drive(input int c, input bit we, input int addr, input int wdata);
    if (c == 0) begin
      bus.c0_req = 1'b1; bus.c0_we = we; bus.c0_addr = ADDR_W'(addr); bus.c0_wdata = DATA_W'(wdata);
    end else begin
      bus.c1_req = 1'b1; bus.c1_we = we; bus.c1_addr = ADDR_W'(addr); bus.c1_wdata = DATA_W'(wdata);
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    drive(0, 1'b1, 'h005, 1);
    repeat (3) cyc();
    #1;
    chk("rst_c0_gnt", bus.c0_gnt, 0);
    chk("rst_write_en", bus.write_en, 0);
    chk("rst_read_en", bus.read_en, 0);
    chk("rst_write_address", bus.write_address, 0);
    chk("rst_data_in", bus.data_in, 0);
    chk("rst_read_address", bus.read_address, 0);
    chk("rst_c0_rvalid", bus.c0_rvalid, 0);
    chk("rst_c1_rvalid", bus.c1_rvalid, 0);
    idle();
    rst = 1'b0;
    cyc();

    // two writes contend: c0 first, c1 next
    drive(0, 1'b1, 'h00A, 244);
    drive(1, 1'b1, 'h00B, 7);
    #1;
    chk("wr2_c0_gnt", bus.c0_gnt, 1);
    chk("wr2_c1_gnt", bus.c1_gnt, 0);
    cyc(); bus.c0_req = 1'b0; #1;
    chk("wr2_c1_gnt_next", bus.c1_gnt, 1);
    chk("wr2_we_a", bus.write_en, 1);
    chk("wr2_addr_a", bus.write_address, 'h00A);
    chk("wr2_data_a", bus.data_in, 244);
    cyc(); bus.c1_req = 1'b0; #1;
    chk("wr2_we_b", bus.write_en, 1);
    chk("wr2_addr_b", bus.write_address, 'h00B);
    chk("wr2_data_b", bus.data_in, 7);
    cyc(); #1;
    chk("wr2_we_idle", bus.write_en, 0);

    // both read continuously for six cycles
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i < 6) begin
        drive(0, 1'b0, 'h00A, 0);
        drive(1, 1'b0, 'h00B, 0);
      end
      #1;
      chk("rd6_c0_gnt", bus.c0_gnt, (i < 6) && (i % 2 == 0));
      chk("rd6_c1_gnt", bus.c1_gnt, (i < 6) && (i % 2 == 1));
      chk("rd6_c0_rvalid", bus.c0_rvalid, (i == 2) || (i == 4) || (i == 6));
      chk("rd6_c1_rvalid", bus.c1_rvalid, (i == 3) || (i == 5) || (i == 7));
      if (bus.c0_rvalid) chk("rd6_c0_rdata", bus.c0_rdata, 244);
      if (bus.c1_rvalid) chk("rd6_c1_rdata", bus.c1_rdata, 7);
      cyc();
    end
    idle();

    // write and read to the same address: read deferred, returns new data
    drive(0, 1'b1, 'h00A, 'h1234);
    drive(1, 1'b0, 'h00A, 0);
    #1;
    chk("haz_c0_gnt", bus.c0_gnt, 1);
    chk("haz_c1_gnt", bus.c1_gnt, 0);
    cyc(); bus.c0_req = 1'b0; #1;
    chk("haz_c1_gnt_next", bus.c1_gnt, 1);
    chk("haz_write_en", bus.write_en, 1);
    cyc(); bus.c1_req = 1'b0; #1;
    chk("haz_read_en", bus.read_en, 1);
    chk("haz_read_address", bus.read_address, 'h00A);
    cyc(); #1;
    chk("haz_c1_rvalid", bus.c1_rvalid, 1);
    chk("haz_c1_rdata", bus.c1_rdata, 'h1234);
    chk("haz_c0_rvalid", bus.c0_rvalid, 0);

    // write and read to different addresses in the same cycle
    drive(0, 1'b1, 'h7FF, 99);
    drive(1, 1'b0, 'h001, 0);
    #1;
    chk("par_c0_gnt", bus.c0_gnt, 1);
    chk("par_c1_gnt", bus.c1_gnt, 1);
    cyc(); idle(); #1;
    chk("par_write_en", bus.write_en, 1);
    chk("par_read_en", bus.read_en, 1);
    chk("par_write_address", bus.write_address, 'h7FF);
    chk("par_data_in", bus.data_in, 99);
    chk("par_read_address", bus.read_address, 'h001);

    // reset with a read in flight
    cyc();
    drive(0, 1'b0, 'h00A, 0);
    #1;
    chk("rstrd_c0_gnt", bus.c0_gnt, 1);
    cyc(); idle(); rst = 1'b1;
    drive(1, 1'b1, 'h003, 3);
    #1;
    chk("rstrd_gnt_in_rst", bus.c1_gnt, 0);
    cyc(); idle(); rst = 1'b0; #1;
    chk("rstrd_c0_rvalid", bus.c0_rvalid, 0);
    chk("rstrd_c1_rvalid", bus.c1_rvalid, 0);
    chk("rstrd_write_en", bus.write_en, 0);
    chk("rstrd_read_en", bus.read_en, 0);
    cyc(); #1;
    chk("rstrd_c0_rvalid_late", bus.c0_rvalid, 0);
    chk("rstrd_c1_rvalid_late", bus.c1_rvalid, 0);
    drive(0, 1'b1, 'h040, 1);
    drive(1, 1'b1, 'h041, 2);
    #1;
    chk("rstrd_pri_c0_gnt", bus.c0_gnt, 1);
    chk("rstrd_pri_c1_gnt", bus.c1_gnt, 0);
    cyc(); bus.c0_req = 1'b0; #1;
    chk("rstrd_c1_gnt_next", bus.c1_gnt, 1);
    cyc(); idle();

    // c1 withdraws while c0 holds priority
    drive(0, 1'b1, 'h010, 5);
    drive(1, 1'b1, 'h020, 6);
    #1;
    chk("wd_c0_gnt", bus.c0_gnt, 1);
    chk("wd_c1_gnt", bus.c1_gnt, 0);
    cyc(); idle(); #1;
    chk("wd_write_en", bus.write_en, 1);
    chk("wd_write_address", bus.write_address, 'h010);
    chk("wd_c1_gnt_after", bus.c1_gnt, 0);
    cyc();
    drive(0, 1'b0, 'h020, 0);
    #1;
    chk("wd_write_en_none", bus.write_en, 0);
    chk("wd_rd_c0_gnt", bus.c0_gnt, 1);
    cyc(); idle();
    cyc(); #1;
    chk("wd_rd_c0_rvalid", bus.c0_rvalid, 1);
    chk("wd_rd_c0_rdata", bus.c0_rdata, 0);

    // sustained one write plus one read per cycle
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i < 4) begin
        drive(0, 1'b1, 'h100 + i, i + 1);
        drive(1, 1'b0, 'h00A, 0);
      end
      #1;
      chk("thr_c0_gnt", bus.c0_gnt, i < 4);
      chk("thr_c1_gnt", bus.c1_gnt, i < 4);
      chk("thr_write_en", bus.write_en, (i >= 1) && (i <= 4));
      chk("thr_read_en", bus.read_en, (i >= 1) && (i <= 4));
      chk("thr_c1_rvalid", bus.c1_rvalid, i >= 2);
      if (i >= 2) chk("thr_c1_rdata", bus.c1_rdata, 'h1234);
      cyc();
    end
    idle();
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 11, RAM address width.
REQ-002 Parameter DATA_W, default 32, RAM data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 cN_req  input  1  client N (N=0,1) command valid; held with fields until granted.
REQ-006 cN_we  input  1  client N command type: 1=write, 0=read.
REQ-007 cN_addr  input  ADDR_W  client N address.
REQ-008 cN_wdata  input  DATA_W  client N write data.
REQ-009 cN_gnt  output  1  client N command accepted this cycle (combinational).
REQ-010 cN_rvalid  output  1  client N read data valid (registered, one-cycle pulse).
REQ-011 cN_rdata  output  DATA_W  client N read data; equals data_out.
REQ-012 write_en, write_address, data_in  output  1/ADDR_W/DATA_W  RAM write port, registered.
REQ-013 read_en, read_address  output  1/ADDR_W  RAM read port, registered.
REQ-014 data_out  input  DATA_W  RAM read data, valid the cycle after read_en.

Function
REQ-015 Write port and read port are arbitrated independently; one write and one read are granted in the same cycle when no hazard exists (REQ-019).
REQ-016 Per port, when only one client requests that port, that client is granted.
REQ-017 Per port, when both clients request it, the client holding priority (wr_pri/rd_pri) wins; the loser's gnt stays low.
REQ-018 After any grant on a port to client k, that port's priority moves to client 1-k; without a grant, priority is unchanged.
REQ-019 Hazard: when the winning write and winning read in a cycle have equal addresses, the read is not granted (write proceeds); the read's priority pointer is unchanged.
REQ-020 A write granted in cycle T drives write_en=1 with its address and data in cycle T+1; write_en=0 in any cycle following a cycle with no write grant.
REQ-021 A read granted in cycle T drives read_en=1 and read_address in T+1; cN_rvalid=1 for the requesting client in T+2; read_en=0 otherwise.
REQ-022 Read ownership is tracked per in-flight slot; back-to-back reads from alternating clients each return rvalid to the correct client, one per cycle.
REQ-023 cN_rdata = data_out continuously; only meaningful when cN_rvalid=1.
REQ-024 A client whose req drops before grant is withdrawn; no RAM access occurs for it.
REQ-025 Write-then-read to the same address in consecutive grant cycles returns the new data (write completes before read samples).
REQ-026 Sustained throughput: one write and one read per cycle, no bubbles.

Reset
REQ-027 While rst=1 at a clock edge: write_en=0, read_en=0, c0_rvalid=c1_rvalid=0, write_address/data_in/read_address=0, wr_pri=rd_pri=client 0.
REQ-028 cN_gnt = 0 while rst=1 regardless of req.
REQ-029 Reset mid-operation discards in-flight reads: no rvalid asserted in the cycles after reset.

Verification
REQ-030 Both clients write (c0 addr 0x00A data 244, c1 addr 0x00B data 7) same cycle -> c0 granted first, c1 next cycle; RAM writes 244@0x00A then 7@0x00B on consecutive cycles.
REQ-031 Both clients read continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; each client receives 3 rvalid pulses, each two cycles after its grant.
REQ-032 c0 write 0x1234@0x00A and c1 read @0x00A same cycle -> write granted, read deferred one cycle; c1_rvalid with rdata 0x1234 three cycles after the original request.
REQ-033 c0 write 99@0x7FF and c1 read @0x001 same cycle -> both granted same cycle; write_en and read_en both high in the next cycle.
REQ-034 Read granted, rst=1 asserted the following cycle -> no rvalid on either client; all RAM strobes 0; after release c0 wins the first contended grant.
REQ-035 c1 req dropped before grant while c0 holds priority -> no c1 grant, no RAM access for c1.
